// File: rtl/udp_roce_connection_manager_tx_512.sv
// Transmit side of the RoCE connection-manager channel.
// Captures one QP-info + tx-metadata record on request acceptance and sends it
// as a UDP frame: one header transfer followed by a single 512-bit payload beat
// that carries the 44-byte metadata record.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_req_* / s_*                 request handshake and record fields (sampled on accept)
//   m_udp_hdr_*, m_ip_*, m_udp_*  UDP/IP header toward the UDP/IP TX stack
//   m_udp_payload_axis_*          payload AXI-Stream (single beat per frame)
//   busy                          high while a frame is in flight
//   tx_frame_count                completed payload beats, wraps at 2^32
module udp_roce_connection_manager_tx_512 #(
  parameter logic [15:0] LOCAL_UDP_PORT = 16'h4321,
  parameter logic [7:0]  IP_TTL         = 8'd64,
  parameter logic [5:0]  IP_DSCP        = 6'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_req_valid,
  output logic         s_req_ready,
  input  logic         s_qp_valid,
  input  logic         s_txmeta_valid,
  input  logic         s_txmeta_start,
  input  logic         s_txmeta_write_type,
  input  logic [23:0]  s_rem_qpn,
  input  logic [23:0]  s_loc_qpn,
  input  logic [23:0]  s_rem_psn,
  input  logic [23:0]  s_loc_psn,
  input  logic [31:0]  s_r_key,
  input  logic [63:0]  s_rem_base_addr,
  input  logic [31:0]  s_rem_ip_addr,
  input  logic [63:0]  s_rem_addr_offset,
  input  logic [31:0]  s_dma_length,
  input  logic [15:0]  s_rem_udp_port,
  input  logic [31:0]  s_local_ip,
  input  logic [31:0]  s_dest_ip,
  input  logic [15:0]  s_dest_port,
  output logic         m_udp_hdr_valid,
  input  logic         m_udp_hdr_ready,
  output logic [5:0]   m_ip_dscp,
  output logic [1:0]   m_ip_ecn,
  output logic [7:0]   m_ip_ttl,
  output logic [31:0]  m_ip_source_ip,
  output logic [31:0]  m_ip_dest_ip,
  output logic [15:0]  m_udp_source_port,
  output logic [15:0]  m_udp_dest_port,
  output logic [15:0]  m_udp_length,
  output logic [15:0]  m_udp_checksum,
  output logic [511:0] m_udp_payload_axis_tdata,
  output logic [63:0]  m_udp_payload_axis_tkeep,
  output logic         m_udp_payload_axis_tvalid,
  input  logic         m_udp_payload_axis_tready,
  output logic         m_udp_payload_axis_tlast,
  output logic         m_udp_payload_axis_tuser,
  output logic         busy,
  output logic [31:0]  tx_frame_count
);

  localparam int unsigned DATA_W        = 512;
  localparam int unsigned KEEP_W        = 64;
  localparam int unsigned PAYLOAD_BYTES = 44;
  localparam int unsigned PAYLOAD_W     = PAYLOAD_BYTES * 8;
  localparam logic [KEEP_W-1:0] KEEP_MASK = 64'h0000_0FFF_FFFF_FFFF;
  localparam logic [15:0] UDP_LEN = 16'd52;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 accept;
  logic                 pay_done;
  logic [31:0]          count_nxt;
  logic [PAYLOAD_W-1:0] record_be;
  logic [DATA_W-1:0]    record_le;

  // Next-state logic; handshakes only count in the state that owns them.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pay_done  = 1'b0;
    case (state)
      IDLE: begin
        accept = s_req_valid & s_req_ready;
        if (accept) state_nxt = HDR;
      end
      HDR: begin
        if (m_udp_hdr_valid & m_udp_hdr_ready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        pay_done = m_udp_payload_axis_tvalid & m_udp_payload_axis_tready;
        if (pay_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    count_nxt = pay_done ? tx_frame_count + 32'd1 : tx_frame_count;
  end

  // Record in wire order (first byte at the MSB end), then byte-reversed so
  // wire byte k lands on tdata[8k+7:8k].
  always_comb begin
    record_be = {7'd0, s_qp_valid, s_rem_qpn, s_loc_qpn, s_rem_psn, s_loc_psn,
                 s_r_key, s_rem_base_addr,
                 5'd0, s_txmeta_write_type, s_txmeta_start, s_txmeta_valid,
                 s_rem_ip_addr, s_rem_addr_offset, s_dma_length, s_rem_udp_port};
    record_le = '0;
    for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
      record_le[8*k +: 8] = record_be[int'(PAYLOAD_W) - 1 - 8*k -: 8];
    end
  end

  // State, handshake flags and captured frame contents.
  always_ff @(posedge clk) begin
    m_ip_dscp                <= IP_DSCP;
    m_ip_ecn                 <= 2'd0;
    m_ip_ttl                 <= IP_TTL;
    m_udp_source_port        <= LOCAL_UDP_PORT;
    m_udp_length             <= UDP_LEN;
    m_udp_checksum           <= 16'd0;
    m_udp_payload_axis_tkeep <= KEEP_MASK;
    m_udp_payload_axis_tuser <= 1'b0;
    if (rst) begin
      state                     <= IDLE;
      s_req_ready               <= 1'b0;
      busy                      <= 1'b0;
      m_udp_hdr_valid           <= 1'b0;
      m_udp_payload_axis_tvalid <= 1'b0;
      m_udp_payload_axis_tlast  <= 1'b0;
      tx_frame_count            <= 32'd0;
      m_ip_source_ip            <= 32'd0;
      m_ip_dest_ip              <= 32'd0;
      m_udp_dest_port           <= 16'd0;
      m_udp_payload_axis_tdata  <= '0;
    end else begin
      state                     <= state_nxt;
      s_req_ready               <= (state_nxt == IDLE);
      busy                      <= (state_nxt != IDLE);
      m_udp_hdr_valid           <= (state_nxt == HDR);
      m_udp_payload_axis_tvalid <= (state_nxt == PAYLOAD);
      m_udp_payload_axis_tlast  <= (state_nxt == PAYLOAD);
      tx_frame_count            <= count_nxt;
      if (accept) begin
        m_ip_source_ip           <= s_local_ip;
        m_ip_dest_ip             <= s_dest_ip;
        m_udp_dest_port          <= s_dest_port;
        m_udp_payload_axis_tdata <= record_le;
      end
    end
  end

endmodule

// File: tb/tb_udp_roce_connection_manager_tx_512.sv
// Directed bench for udp_roce_connection_manager_tx_512: cycle-exact handshake
// timing, payload byte placement, stall stability, back-to-back frames,
// mid-frame reset and frame-counter wrap.
module tb_udp_roce_connection_manager_tx_512;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_req_valid, s_req_ready;
  logic         s_qp_valid, s_txmeta_valid, s_txmeta_start, s_txmeta_write_type;
  logic [23:0]  s_rem_qpn, s_loc_qpn, s_rem_psn, s_loc_psn;
  logic [31:0]  s_r_key;
  logic [63:0]  s_rem_base_addr;
  logic [31:0]  s_rem_ip_addr;
  logic [63:0]  s_rem_addr_offset;
  logic [31:0]  s_dma_length;
  logic [15:0]  s_rem_udp_port;
  logic [31:0]  s_local_ip, s_dest_ip;
  logic [15:0]  s_dest_port;
  logic         hdr_valid, hdr_ready;
  logic [5:0]   ip_dscp;
  logic [1:0]   ip_ecn;
  logic [7:0]   ip_ttl;
  logic [31:0]  ip_src, ip_dst;
  logic [15:0]  udp_sport, udp_dport, udp_len, udp_csum;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid, tready, tlast, tuser;
  logic         busy;
  logic [31:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  int frames = 0;
  int frames_ref;

  udp_roce_connection_manager_tx_512 dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_qp_valid(s_qp_valid), .s_txmeta_valid(s_txmeta_valid),
    .s_txmeta_start(s_txmeta_start), .s_txmeta_write_type(s_txmeta_write_type),
    .s_rem_qpn(s_rem_qpn), .s_loc_qpn(s_loc_qpn), .s_rem_psn(s_rem_psn), .s_loc_psn(s_loc_psn),
    .s_r_key(s_r_key), .s_rem_base_addr(s_rem_base_addr), .s_rem_ip_addr(s_rem_ip_addr),
    .s_rem_addr_offset(s_rem_addr_offset), .s_dma_length(s_dma_length),
    .s_rem_udp_port(s_rem_udp_port), .s_local_ip(s_local_ip), .s_dest_ip(s_dest_ip),
    .s_dest_port(s_dest_port),
    .m_udp_hdr_valid(hdr_valid), .m_udp_hdr_ready(hdr_ready),
    .m_ip_dscp(ip_dscp), .m_ip_ecn(ip_ecn), .m_ip_ttl(ip_ttl),
    .m_ip_source_ip(ip_src), .m_ip_dest_ip(ip_dst),
    .m_udp_source_port(udp_sport), .m_udp_dest_port(udp_dport),
    .m_udp_length(udp_len), .m_udp_checksum(udp_csum),
    .m_udp_payload_axis_tdata(tdata), .m_udp_payload_axis_tkeep(tkeep),
    .m_udp_payload_axis_tvalid(tvalid), .m_udp_payload_axis_tready(tready),
    .m_udp_payload_axis_tlast(tlast), .m_udp_payload_axis_tuser(tuser),
    .busy(busy), .tx_frame_count(count)
  );

  always #5 clk = ~clk;

  // Count payload handshakes independently of the DUT counter.
  always @(posedge clk) if (!rst && tvalid && tready) frames <= frames + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fields();
    s_qp_valid = 1'b0; s_txmeta_valid = 1'b0; s_txmeta_start = 1'b0; s_txmeta_write_type = 1'b0;
    s_rem_qpn = '0; s_loc_qpn = '0; s_rem_psn = '0; s_loc_psn = '0;
    s_r_key = '0; s_rem_base_addr = '0; s_rem_ip_addr = '0; s_rem_addr_offset = '0;
    s_dma_length = '0; s_rem_udp_port = '0; s_local_ip = '0; s_dest_ip = '0; s_dest_port = '0;
  endtask

  initial begin
    rst = 1'b1; s_req_valid = 1'b0; hdr_ready = 1'b0; tready = 1'b0;
    clear_fields();

    // Test 1: reset state, then a basic frame with exact latency.
    step(); step();
    check("rst_ready", 512'(s_req_ready), 512'(1'b0));
    check("rst_hdr_valid", 512'(hdr_valid), 512'(1'b0));
    check("rst_tvalid", 512'(tvalid), 512'(1'b0));
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_count", 512'(count), 512'(32'd0));
    rst = 1'b0;
    step();
    check("idle_ready", 512'(s_req_ready), 512'(1'b1));
    s_rem_qpn = 24'h123456; s_r_key = 32'hDEADBEEF;
    s_local_ip = 32'hC0A8_0001; s_dest_ip = 32'hC0A8_0002; s_dest_port = 16'd4791;
    hdr_ready = 1'b1; tready = 1'b1; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    check("t1_hdr_valid_n1", 512'(hdr_valid), 512'(1'b1));
    check("t1_ready_low", 512'(s_req_ready), 512'(1'b0));
    check("t1_udp_len", 512'(udp_len), 512'(16'd52));
    check("t1_csum", 512'(udp_csum), 512'(16'd0));
    check("t1_sport", 512'(udp_sport), 512'(16'h4321));
    check("t1_dport", 512'(udp_dport), 512'(16'd4791));
    check("t1_ttl", 512'(ip_ttl), 512'(8'd64));
    check("t1_ecn_dscp", 512'({ip_ecn, ip_dscp}), 512'(8'd0));
    check("t1_src_ip", 512'(ip_src), 512'(32'hC0A8_0001));
    check("t1_dst_ip", 512'(ip_dst), 512'(32'hC0A8_0002));
    check("t1_tvalid_n1", 512'(tvalid), 512'(1'b0));
    step();
    check("t1_tvalid_n2", 512'(tvalid), 512'(1'b1));
    check("t1_hdr_valid_n2", 512'(hdr_valid), 512'(1'b0));
    check("t1_qpn", 512'(tdata[31:8]), 512'(24'h563412));
    check("t1_rkey", 512'(tdata[135:104]), 512'(32'hEFBEADDE));
    check("t1_byte0", 512'(tdata[7:0]), 512'(8'h00));
    step();
    check("t1_tvalid_n3", 512'(tvalid), 512'(1'b0));
    check("t1_count", 512'(count), 512'(32'd1));
    check("t1_busy_n3", 512'(busy), 512'(1'b0));
    check("t1_ready_n3", 512'(s_req_ready), 512'(1'b1));

    // Test 2: flag bits and beat framing.
    clear_fields();
    s_qp_valid = 1'b1; s_txmeta_valid = 1'b1; s_txmeta_start = 1'b1; s_txmeta_write_type = 1'b0;
    s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    step();
    check("t2_tvalid", 512'(tvalid), 512'(1'b1));
    check("t2_qp_valid", 512'(tdata[0]), 512'(1'b1));
    check("t2_flags", 512'(tdata[207:200]), 512'(8'h03));
    check("t2_tkeep", 512'(tkeep), 512'(64'h0000_0FFF_FFFF_FFFF));
    check("t2_tlast", 512'(tlast), 512'(1'b1));
    check("t2_tuser", 512'(tuser), 512'(1'b0));
    check("t2_upper_zero", 512'(tdata[511:352]), 512'(160'd0));
    step();
    check("t2_count", 512'(count), 512'(32'd2));

    // Test 3: header and payload stalls with inputs changing underneath.
    clear_fields();
    s_loc_qpn = 24'hABCDEF; s_dma_length = 32'h0102_0304; s_rem_udp_port = 16'hBEEF;
    s_rem_base_addr = 64'h1122_3344_5566_7788; s_dest_ip = 32'h0A00_0002;
    hdr_ready = 1'b0; tready = 1'b1; s_req_valid = 1'b1;
    frames_ref = frames;
    step();
    s_req_valid = 1'b0;
    s_loc_qpn = 24'h0; s_dma_length = 32'hFFFF_FFFF; s_dest_ip = 32'hFFFF_FFFF; s_rem_udp_port = 16'h0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hdr_hold", 512'(hdr_valid), 512'(1'b1));
      check("t3_hdr_dst_ip", 512'(ip_dst), 512'(32'h0A00_0002));
      check("t3_hdr_ready_low", 512'(s_req_ready), 512'(1'b0));
      step();
    end
    hdr_ready = 1'b1;
    step();
    hdr_ready = 1'b0; tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_tvalid_hold", 512'(tvalid), 512'(1'b1));
      check("t3_loc_qpn", 512'(tdata[55:32]), 512'(24'hEFCDAB));
      check("t3_base_addr", 512'(tdata[199:136]), 512'(64'h8877_6655_4433_2211));
      check("t3_dma_len", 512'(tdata[335:304]), 512'(32'h0403_0201));
      check("t3_udp_port", 512'(tdata[351:336]), 512'(16'hEFBE));
      check("t3_pay_ready_low", 512'(s_req_ready), 512'(1'b0));
      step();
    end
    tready = 1'b1;
    step();
    check("t3_one_frame", 512'(frames - frames_ref), 512'(1));
    check("t3_count", 512'(count), 512'(32'd3));

    // Test 4: back-to-back requests with valid held.
    clear_fields();
    hdr_ready = 1'b1; tready = 1'b1;
    s_rem_psn = 24'h000001; s_req_valid = 1'b1;
    step();
    s_rem_psn = 24'hA1B2C3;
    check("t4_ready_low_a", 512'(s_req_ready), 512'(1'b0));
    step();
    check("t4_frame_a_psn", 512'(tdata[79:56]), 512'(24'h010000));
    check("t4_ready_low_b", 512'(s_req_ready), 512'(1'b0));
    step();
    check("t4_busy_gap", 512'(busy), 512'(1'b0));
    check("t4_ready_gap", 512'(s_req_ready), 512'(1'b1));
    step();
    s_req_valid = 1'b0;
    check("t4_busy_again", 512'(busy), 512'(1'b1));
    check("t4_hdr_b", 512'(hdr_valid), 512'(1'b1));
    step();
    check("t4_frame_b_psn", 512'(tdata[79:56]), 512'(24'hC3B2A1));
    step();
    check("t4_count", 512'(count), 512'(32'd5));
    check("t4_idle", 512'(busy), 512'(1'b0));

    // Test 5: reset while stalled in PAYLOAD, then a clean frame.
    clear_fields();
    s_rem_qpn = 24'h0000AA; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    tready = 1'b0;
    step();
    check("t5_in_payload", 512'(tvalid), 512'(1'b1));
    rst = 1'b1;
    step();
    check("t5_tvalid", 512'(tvalid), 512'(1'b0));
    check("t5_hdr_valid", 512'(hdr_valid), 512'(1'b0));
    check("t5_busy", 512'(busy), 512'(1'b0));
    check("t5_count", 512'(count), 512'(32'd0));
    rst = 1'b0; tready = 1'b1;
    step();
    s_rem_qpn = 24'h00BEEF; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    check("t5_hdr", 512'(hdr_valid), 512'(1'b1));
    step();
    check("t5_qpn", 512'(tdata[31:8]), 512'(24'hEFBE00));
    step();
    check("t5_count_after", 512'(count), 512'(32'd1));

    // Test 6: counter wrap from all-ones.
    force dut.tx_frame_count = 32'hFFFF_FFFF;
    step();
    release dut.tx_frame_count;
    step();
    check("t6_preload", 512'(count), 512'(32'hFFFF_FFFF));
    s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    step(); step();
    check("t6_wrap", 512'(count), 512'(32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
